alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the same opcode encodings 0-7 and adds add/sub with carry, barrel shifts and a multi-cycle shift-add multiply.
- Adds valid/ready handshakes on input and output, plus a full flag set (carry, zero, negative, overflow).
- Sits between an operand/issue stage and a writeback stage; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (shift amount in low SHW bits for shifts).
- sel  in  4  opcode.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- carry  out  1  registered carry/borrow flag.
- zero  out  1  registered, result==0.
- neg  out  1  registered, result[WIDTH-1].
- ovf  out  1  registered signed overflow.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (async, rst_n=0): result=0, carry=0, zero=0, neg=0, ovf=0, out_valid=0, busy=0, stored carry-in cflag=0, FSM=IDLE. Reset mid-multiply abandons the operation; no result is produced.
- Accept: the operation is accepted at a clock edge when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready), so a result can be drained and a new operation accepted in the same edge.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT a.
  - 6 PASS b.
  - 7 PASS a.
  - 8 ADC: a+b+cflag.
  - 9 SBB: a-b-cflag.
  - 10 SHL: a<<b[SHW-1:0].
  - 11 SHR (logical): a>>b[SHW-1:0].
  - 12 MUL: low WIDTH bits of a*b, unsigned.
  - 13-15 reserved: result=0, all flags 0 except zero=1.
- Single-cycle ops (all except MUL): result and flags are loaded at the accept edge; out_valid=1 from the next cycle. Latency is 1 cycle.
- Carry flag:
  - ADD/ADC: carry-out of a WIDTH+1-bit sum.
  - SUB/SBB: borrow, i.e. 1 when a < b(+cflag) unsigned.
  - SHL: last bit shifted out, a[WIDTH-amt].
  - SHR: a[amt-1].
  - Shift amount 0: carry=0.
  - Logic, pass and reserved ops: carry=0.
- ovf: signed overflow for ADD/SUB/ADC/SBB (operand signs equal and result sign differs, with b taken inverted for subtract); 0 for all other ops.
- zero and neg are always computed from the loaded result.
- cflag is updated to the new carry value whenever an ADD/SUB/ADC/SBB/SHL/SHR/MUL result is loaded; it is unchanged by other ops. ADC/SBB use cflag as it stands at their accept edge, so back-to-back ADC chains correctly with no bubble.
- FSM states:
  - IDLE: MUL accept captures a, b and clears the product accumulator; go to MUL.
  - MUL: one shift-add step per cycle, WIDTH cycles total; busy=1; in_ready=0. On the final step go to IDLE, load result with the low half, set carry=1 if the high half ≠0, set ovf=0. out_valid rises the cycle after the last step. MUL latency = WIDTH+1 cycles from the accept edge to out_valid.
  - The MUL→IDLE step loads the output register only when !out_valid || out_ready; otherwise the FSM stalls in MUL on its final step.
- Output hold: while out_valid && !out_ready, result and all flags are held stable.
- out_valid clears when out_ready=1 and there is no new load in that edge.
- Inputs are ignored when in_ready=0, regardless of in_valid.

Test Plan (WIDTH=8):
- Reset, then ADD a=0xF0 b=0x20 → next cycle out_valid=1, result=0x10, carry=1, zero=0, ovf=0. Then ADD 0x7F+0x01 → 0x80, neg=1, ovf=1, carry=0.
- SUB 0x05-0x05 → result=0, zero=1, carry=0. SUB 0x03-0x05 → 0xFE, carry=1, neg=1.
- 16-bit chain: ADD 0xFF+0x01 then ADC 0x00+0x00 on consecutive cycles → results 0x00 (carry=1), then 0x01.
- MUL 0x13*0x11 → out_valid exactly 9 cycles after accept; result=0x43, carry=1; in_ready=0 and busy=1 throughout; hold out_ready=0 for 3 cycles and check result stays stable.
- SHL a=0x81 amt=1 → result=0x02, carry=1. SHR a=0x81 amt=0 → result=0x81, carry=0. Opcode 14 → result=0, zero=1.
- Assert rst_n low during MUL cycle 4 → all outputs 0 immediately; after release no stale result appears; the next ADD works and ADC sees cflag=0.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, full flag set and a multi-cycle
// shift-add multiplier; one operation in flight at a time.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_PSB = 4'd6;
  localparam logic [3:0] OP_PSA = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state, state_next;

  logic               cflag;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic               can_load, accept, mul_start, ld_single, ld_mul, ld_any, upd_cflag;
  logic [SHW-1:0]     amt;
  logic               cin, bin;
  logic [WIDTH:0]     sum, diff, shl_w, shr_w;
  logic [WIDTH-1:0]   op_res, new_res;
  logic               op_c, op_v, op_cupd, new_c, new_v;

  // Signed overflow from operand/result sign bits; subtract passes b inverted.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign can_load  = !out_valid || out_ready;
  assign in_ready  = (state == ST_IDLE) && can_load;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (sel == OP_MUL);
  assign ld_single = accept && (sel != OP_MUL);
  assign ld_mul    = (state == ST_MUL) && (cnt == CW'(WIDTH)) && can_load;
  assign ld_any    = ld_single || ld_mul;
  assign busy      = (state == ST_MUL);

  assign amt   = b[SHW-1:0];
  assign cin   = (sel == OP_ADC) ? cflag : 1'b0;
  assign bin   = (sel == OP_SBB) ? cflag : 1'b0;
  assign sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  // The extra bit catches the last bit shifted out; it stays 0 for amt==0.
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;

  always_comb begin
    op_res  = '0;
    op_c    = 1'b0;
    op_v    = 1'b0;
    op_cupd = 1'b0;
    case (sel)
      OP_ADD, OP_ADC: begin
        op_res  = sum[WIDTH-1:0];
        op_c    = sum[WIDTH];
        op_v    = ovf_flag(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
        op_cupd = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        op_res  = diff[WIDTH-1:0];
        op_c    = diff[WIDTH];
        op_v    = ovf_flag(a[WIDTH-1], ~b[WIDTH-1], diff[WIDTH-1]);
        op_cupd = 1'b1;
      end
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_XOR: op_res = a ^ b;
      OP_NOT: op_res = ~a;
      OP_PSB: op_res = b;
      OP_PSA: op_res = a;
      OP_SHL: begin
        op_res  = shl_w[WIDTH-1:0];
        op_c    = shl_w[WIDTH];
        op_cupd = 1'b1;
      end
      OP_SHR: begin
        op_res  = shr_w[WIDTH:1];
        op_c    = shr_w[0];
        op_cupd = 1'b1;
      end
      default: ;
    endcase
  end

  assign new_res   = ld_mul ? acc[WIDTH-1:0] : op_res;
  assign new_c     = ld_mul ? |acc[2*WIDTH-1:WIDTH] : op_c;
  assign new_v     = ld_mul ? 1'b0 : op_v;
  assign upd_cflag = ld_mul || (ld_single && op_cupd);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (ld_mul)    state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      cflag     <= 1'b0;
    end else begin
      state <= state_next;
      if (mul_start)
        cnt <= '0;
      else if ((state == ST_MUL) && (cnt < CW'(WIDTH)))
        cnt <= cnt + CW'(1);
      if (ld_any) begin
        result    <= new_res;
        carry     <= new_c;
        zero      <= (new_res == '0);
        neg       <= new_res[WIDTH-1];
        ovf       <= new_v;
        out_valid <= 1'b1;
        if (upd_cflag) cflag <= new_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Shift-add multiplier datapath; the step after the last one only loads the result
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if ((state == ST_MUL) && (cnt < CW'(WIDTH))) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule
